if_fetch_unit: RTL and testbench

//  Instruction-fetch stage of the 5-stage MIPS pipeline; the producer side of the IF/ID pipeline register.

---
 rtl/if_fetch_unit.sv | 177 +++++++++++++++++
 tb/tb_if_fetch_unit.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/if_fetch_unit.sv
// Instruction-fetch stage: owns the PC, keeps one request in flight to
// instruction memory and feeds {pc+4, instr} or flush bubbles into IF/ID.
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0000,
  parameter logic [31:0] INIT_COUNT = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        ifid_ld,
  output logic [63:0] ifid_data,
  output logic [31:0] pc,
  output logic [31:0] instr_count
);

  typedef enum logic [1:0] {
    S_REQ  = 2'd0,
    S_WAIT = 2'd1,
    S_HOLD = 2'd2
  } state_e;

  state_e      state_q;
  state_e      state_d;
  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] hold_q;
  logic [31:0] hold_d;
  logic [31:0] cnt_q;
  logic [31:0] cnt_d;
  logic        discard_q;
  logic        discard_d;
  logic        ld_q;
  logic        ld_d;
  logic [63:0] data_q;
  logic [63:0] data_d;

  logic [31:0] pc_plus4;
  logic [31:0] redirect_tgt;
  logic [31:0] dword;
  logic        flush;
  logic        deliver;
  logic        capture;
  logic        set_discard;

  assign pc_plus4     = pc_q + 32'd4;
  assign redirect_tgt = redirect_pc & ~32'h3;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_REQ;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_REQ: begin
        if (!redirect && imem_ready) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (redirect) begin
          if (imem_rvalid) begin
            state_d = S_REQ;
          end
        end else if (imem_rvalid) begin
          if (discard_q || !stall) begin
            state_d = S_REQ;
          end else begin
            state_d = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (redirect || !stall) begin
          state_d = S_REQ;
        end
      end
      default: state_d = S_REQ;
    endcase
  end

  // event decode: which of flush / deliver / capture fires this cycle
  always_comb begin
    flush       = redirect;
    deliver     = 1'b0;
    capture     = 1'b0;
    set_discard = 1'b0;
    dword       = imem_rdata;
    unique case (state_q)
      S_REQ: begin
        deliver = 1'b0;
      end
      S_WAIT: begin
        set_discard = redirect && !imem_rvalid;
        deliver = !redirect && imem_rvalid
                  && !discard_q && !stall;
        capture = !redirect && imem_rvalid
                  && !discard_q && stall;
      end
      S_HOLD: begin
        deliver = !redirect && !stall;
        dword   = hold_q;
      end
      default: begin
        deliver = 1'b0;
      end
    endcase
  end

  always_comb begin
    pc_d   = pc_q;
    cnt_d  = cnt_q;
    hold_d = hold_q;
    data_d = data_q;
    ld_d   = 1'b0;
    // a late response is only owed while still waiting on it
    discard_d = (state_d == S_WAIT)
                && (discard_q || set_discard);
    unique case (1'b1)
      flush: begin
        ld_d   = 1'b1;
        data_d = {32'h0, NOP_INSTR};
        pc_d   = redirect_tgt;
      end
      deliver: begin
        ld_d   = 1'b1;
        data_d = {pc_plus4, dword};
        pc_d   = pc_plus4;
        cnt_d  = cnt_q + 32'd1;
      end
      capture: begin
        hold_d = imem_rdata;
      end
      default: begin
        ld_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q      <= RESET_PC;
      cnt_q     <= INIT_COUNT;
      hold_q    <= 32'h0;
      data_q    <= 64'h0;
      ld_q      <= 1'b0;
      discard_q <= 1'b0;
    end else begin
      pc_q      <= pc_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      data_q    <= data_d;
      ld_q      <= ld_d;
      discard_q <= discard_d;
    end
  end

  assign imem_req    = (state_q == S_REQ) && !redirect && !reset;
  assign imem_addr   = pc_q;
  assign ifid_ld     = ld_q;
  assign ifid_data   = data_q;
  assign pc          = pc_q;
  assign instr_count = cnt_q;

endmodule

// File: tb/tb_if_fetch_unit.sv
// Directed bench for if_fetch_unit: scoreboard of expected IF/ID strobes
// plus direct checks of pc, count and request outputs.
module tb_if_fetch_unit;

  logic        clk;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        ifid_ld;
  logic [63:0] ifid_data;
  logic [31:0] pc;
  logic [31:0] instr_count;

  logic        b_reset;
  logic        b_ready;
  logic        b_rvalid;
  logic [31:0] b_rdata;
  logic        b_req;
  logic [31:0] b_addr;
  logic        b_ld;
  logic [63:0] b_data;
  logic [31:0] b_pc;
  logic [31:0] b_cnt;

  if_fetch_unit dut (
    .clk         (clk),
    .reset       (reset),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ready  (imem_ready),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .ifid_ld     (ifid_ld),
    .ifid_data   (ifid_data),
    .pc          (pc),
    .instr_count (instr_count)
  );

  if_fetch_unit #(
    .RESET_PC   (32'hFFFF_FFFC),
    .INIT_COUNT (32'hFFFF_FFFF)
  ) dut_b (
    .clk         (clk),
    .reset       (b_reset),
    .stall       (1'b0),
    .redirect    (1'b0),
    .redirect_pc (32'h0),
    .imem_req    (b_req),
    .imem_addr   (b_addr),
    .imem_ready  (b_ready),
    .imem_rvalid (b_rvalid),
    .imem_rdata  (b_rdata),
    .ifid_ld     (b_ld),
    .ifid_data   (b_data),
    .pc          (b_pc),
    .instr_count (b_cnt)
  );

  typedef struct {
    int          at;
    logic [63:0] data;
  } exp_t;

  exp_t q[$];
  int   total = 0;
  int   bad   = 0;
  int   n     = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [63:0] obs,
                     input logic [63:0] want);
    total++;
    assert (obs === want) else begin
      bad++;
      $error("FAIL %s: got %h want %h", tag, obs, want);
    end
  endtask

  task automatic push(input logic [63:0] d);
    exp_t e;
    e.at   = n + 1;
    e.data = d;
    q.push_back(e);
  endtask

  // checks IF/ID against the scoreboard, then advances one cycle
  task automatic cyc();
    exp_t e;
    @(negedge clk);
    if (ifid_ld === 1'b1) begin
      if (q.size() == 0) begin
        chk("spurious_ld", {63'h0, ifid_ld}, 64'h0);
      end else begin
        e = q.pop_front();
        chk("ld_cycle", 64'(n), 64'(e.at));
        chk("ld_data", ifid_data, e.data);
      end
    end else if (q.size() != 0 && q[0].at <= n) begin
      e = q.pop_front();
      chk("missing_ld", {63'h0, ifid_ld}, 64'h1);
    end
    @(posedge clk);
    #1;
    n++;
  endtask

  initial begin
    reset = 1'b1;
    stall = 1'b0;
    redirect = 1'b0;
    redirect_pc = 32'h0;
    imem_ready = 1'b0;
    imem_rvalid = 1'b0;
    imem_rdata = 32'h0;
    b_reset = 1'b1;
    b_ready = 1'b0;
    b_rvalid = 1'b0;
    b_rdata = 32'h0;
    cyc();
    cyc();
    chk("rst_pc", pc, 32'h0);
    chk("rst_ld", {63'h0, ifid_ld}, 64'h0);
    chk("rst_data", ifid_data, 64'h0);
    chk("rst_cnt", instr_count, 32'h0);
    chk("rst_req", {63'h0, imem_req}, 64'h0);

    // 1: plain fetch, data one cycle after accept
    reset = 1'b0;
    imem_ready = 1'b1;
    #1;
    chk("t1_req", {63'h0, imem_req}, 64'h1);
    chk("t1_addr", imem_addr, 32'h0);
    cyc();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h2008_0005;
    push({32'h4, 32'h2008_0005});
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("t1_pc", pc, 32'h4);
    chk("t1_cnt", instr_count, 32'h1);
    chk("t1_req2", {63'h0, imem_req}, 64'h1);
    chk("t1_addr2", imem_addr, 32'h4);

    // 2: stall held across accept, rvalid and one hold cycle
    stall = 1'b1;
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'hAC01_0000;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("t2_hold_req", {63'h0, imem_req}, 64'h0);
    cyc();
    chk("t2_hold_pc", pc, 32'h4);
    stall = 1'b0;
    push({32'h8, 32'hAC01_0000});
    cyc();
    #1;
    chk("t2_pc", pc, 32'h8);
    chk("t2_cnt", instr_count, 32'h2);

    // 3: redirect while waiting; late response dropped
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0043;
    push({32'h0, 32'h0});
    cyc();
    redirect = 1'b0;
    #1;
    chk("t3_pc", pc, 32'h40);
    chk("t3_req", {63'h0, imem_req}, 64'h0);
    cyc();
    imem_rvalid = 1'b1;
    imem_rdata = 32'hDEAD_BEEF;
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("t3_cnt", instr_count, 32'h2);
    chk("t3_req2", {63'h0, imem_req}, 64'h1);
    chk("t3_addr", imem_addr, 32'h40);

    // 4: redirect and stall together in hold
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    stall = 1'b1;
    imem_rdata = 32'hBADC_0FFE;
    cyc();
    imem_rvalid = 1'b0;
    redirect = 1'b1;
    redirect_pc = 32'h0000_0100;
    push({32'h0, 32'h0});
    cyc();
    redirect = 1'b0;
    stall = 1'b0;
    cyc();
    cyc();
    chk("t4_pc", pc, 32'h100);
    chk("t4_data", ifid_data, 64'h0);
    chk("t4_cnt", instr_count, 32'h2);
    chk("t4_addr", imem_addr, 32'h100);

    // redirect in S_REQ suppresses the request
    redirect = 1'b1;
    redirect_pc = 32'h0000_00C9;
    imem_ready = 1'b1;
    #1;
    chk("rq_req", {63'h0, imem_req}, 64'h0);
    push({32'h0, 32'h0});
    cyc();
    redirect = 1'b0;
    imem_ready = 1'b0;
    #1;
    chk("rq_pc", pc, 32'hC8);
    chk("rq_req2", {63'h0, imem_req}, 64'h1);
    imem_rvalid = 1'b1;
    imem_rdata = 32'h5555_AAAA;
    cyc();
    imem_rvalid = 1'b0;
    cyc();
    chk("rq_ign_req", {63'h0, imem_req}, 64'h1);
    chk("rq_ign_cnt", instr_count, 32'h2);

    // 6: reset in S_WAIT with rvalid in the same cycle
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    reset = 1'b1;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h0000_1234;
    cyc();
    reset = 1'b0;
    imem_rvalid = 1'b0;
    #1;
    chk("t6_pc", pc, 32'h0);
    chk("t6_cnt", instr_count, 32'h0);
    chk("t6_ld", {63'h0, ifid_ld}, 64'h0);
    chk("t6_data", ifid_data, 64'h0);
    chk("t6_req", {63'h0, imem_req}, 64'h1);
    chk("t6_addr", imem_addr, 32'h0);
    imem_ready = 1'b1;
    cyc();
    imem_ready = 1'b0;
    imem_rvalid = 1'b1;
    imem_rdata = 32'h1111_2222;
    push({32'h4, 32'h1111_2222});
    cyc();
    imem_rvalid = 1'b0;
    #1;
    chk("t6_cnt2", instr_count, 32'h1);
    cyc();
    cyc();
    chk("sb_empty", 64'(q.size()), 64'h0);

    // 5: pc and count wrap on a second instance
    b_reset = 1'b0;
    b_ready = 1'b1;
    #1;
    chk("t5_rst_pc", b_pc, 32'hFFFF_FFFC);
    chk("t5_req", {63'h0, b_req}, 64'h1);
    chk("t5_addr", b_addr, 32'hFFFF_FFFC);
    cyc();
    b_ready = 1'b0;
    b_rvalid = 1'b1;
    b_rdata = 32'h0BAD_F00D;
    cyc();
    b_rvalid = 1'b0;
    #1;
    chk("t5_ld", {63'h0, b_ld}, 64'h1);
    chk("t5_data", b_data, {32'h0, 32'h0BAD_F00D});
    chk("t5_pc", b_pc, 32'h0);
    chk("t5_cnt", b_cnt, 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
